// File: rtl/ifetch_if.sv
// Memory read bus and instruction delivery bus of the fetch unit.
interface ifetch_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ack_i;

    modport master (
        output mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ack_i
    );
    modport slave (
        input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ack_i
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: credit-limited sequential prefetch into a FWFT buffer,
// with flush redirect that silently drains stale in-flight responses.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        halt_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    ifetch_if.master    bus
);
    localparam int          PW    = $clog2(DEPTH);
    localparam int          CW    = PW + 1;
    localparam logic [CW:0] CAP   = (CW+1)'(DEPTH);
    localparam logic [31:0] RST_A = {RESET_PC[31:2], 2'b00};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ibuf_ent_t;

    ibuf_ent_t [DEPTH-1:0] ibuf_q;
    ibuf_ent_t             head;
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]         count_q, outst_q, discard_q, outst_d;
    logic [31:0]           fetch_pc_q, resp_pc_q, flush_a;
    logic [CW:0]           inflight;
    logic                  gnt_fire, rsp_fire, rsp_drop, push, pop;

    // Buffered plus in-flight words never exceed DEPTH, so a push always has room.
    assign inflight      = {1'b0, count_q} + {1'b0, outst_q};
    assign bus.mem_req_o = reset_ni && !halt_i && !flush_i && (inflight < CAP);
    assign bus.mem_addr_o = fetch_pc_q;

    assign gnt_fire = bus.mem_req_o && bus.mem_gnt_i;
    assign rsp_fire = bus.mem_rvalid_i && (outst_q != '0);
    assign rsp_drop = rsp_fire && (discard_q != '0);
    assign push     = rsp_fire && !rsp_drop && !flush_i;
    assign pop      = (count_q != '0) && bus.inst_ack_i && !flush_i;
    assign outst_d  = outst_q + CW'(gnt_fire) - CW'(rsp_fire);
    assign flush_a  = {flush_pc_i[31:2], 2'b00};

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            fetch_pc_q <= RST_A;
            resp_pc_q  <= RST_A;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            outst_q <= outst_d;
            if (flush_i) begin
                // Everything still in flight after this cycle's retire is stale.
                fetch_pc_q <= flush_a;
                resp_pc_q  <= flush_a;
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                discard_q  <= outst_d;
            end else begin
                if (gnt_fire) fetch_pc_q <= fetch_pc_q + 32'd4;
                if (rsp_drop) discard_q  <= discard_q - CW'(1);
                if (push) begin
                    resp_pc_q <= resp_pc_q + 32'd4;
                    wr_ptr_q  <= wr_ptr_q + PW'(1);
                end
                if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) ibuf_q[wr_ptr_q] <= '{pc: resp_pc_q, word: bus.mem_rdata_i};
    end

    assign head             = ibuf_q[rd_ptr_q];
    assign bus.inst_valid_o = (count_q != '0);
    assign bus.inst_o       = bus.inst_valid_o ? head.word : 32'h0;
    assign bus.inst_pc_o    = bus.inst_valid_o ? head.pc   : 32'h0;
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, instruction buffer entries; power of two, 2..16.
REQ-003 clk_i  in  1  sole clock, all state updates on rising edge.
REQ-004 reset_ni  in  1  synchronous reset, active-low.
REQ-005 mem_req_o  out  1  read request valid.
REQ-006 mem_addr_o  out  32  word-aligned read address.
REQ-007 mem_gnt_i  in  1  request accepted when mem_req_o && mem_gnt_i.
REQ-008 mem_rvalid_i  in  1  read data valid; responses in request order, at least 1 cycle after grant.
REQ-009 mem_rdata_i  in  32  read data.
REQ-010 inst_valid_o  out  1  buffer head holds an instruction.
REQ-011 inst_o  out  32  head instruction word.
REQ-012 inst_pc_o  out  32  address of head instruction.
REQ-013 inst_ack_i  in  1  consumer takes head when inst_valid_o && inst_ack_i.
REQ-014 halt_i  in  1  suppress new memory requests.
REQ-015 flush_i  in  1  discard buffered/in-flight fetches and redirect.
REQ-016 flush_pc_i  in  32  redirect target.

Function
REQ-017 fetch_pc register holds next request address; mem_addr_o = fetch_pc (combinational).
REQ-018 mem_req_o = !halt_i && !flush_i && (count + outstanding) < DEPTH; never asserted while reset_ni low.
REQ-019 On grant: fetch_pc += 4, mod 2^32 (32'hFFFF_FFFC wraps to 0); outstanding += 1.
REQ-020 On mem_rvalid_i: outstanding -= 1; if discard > 0, discard -= 1 and data dropped; else {resp_pc, mem_rdata_i} pushed and resp_pc += 4 (same wrap).
REQ-021 Grant and response in same cycle: outstanding unchanged.
REQ-022 Buffer is first-word-fall-through: inst_valid_o = (count != 0); inst_o/inst_pc_o driven from head entry, stable while not acked.
REQ-023 Pop on inst_valid_o && inst_ack_i; inst_ack_i with empty buffer ignored.
REQ-024 Push and pop same cycle: count unchanged, order preserved; credit rule (REQ-018) guarantees no push when full.
REQ-025 Minimum latency: grant cycle N, rvalid N+1, inst_valid_o high in cycle N+2.
REQ-026 Sustained throughput with gnt=1, 1-cycle response, ack=1: one instruction per cycle.
REQ-027 flush_i has priority over all other events in that cycle: buffer emptied (count 0), pop ignored, fetch_pc and resp_pc <= {flush_pc_i[31:2], 2'b00}.
REQ-028 On flush: discard <= outstanding after this cycle's response is retired; the response in the flush cycle itself is dropped.
REQ-029 halt_i blocks only new requests; in-flight responses still fill buffer; buffer still drains.
REQ-030 mem_rvalid_i with outstanding == 0 is ignored; outstanding and discard never underflow.
REQ-031 outstanding, discard, count widths $clog2(DEPTH)+1; discard <= outstanding at all times.

Reset
REQ-032 While reset_ni low, at the clock edge: fetch_pc, resp_pc <= RESET_PC; count, outstanding, discard <= 0.
REQ-033 Outputs during/after reset: mem_req_o 0 while in reset, inst_valid_o 0, inst_o 0, inst_pc_o 0 (empty head reads zero).
REQ-034 Reset mid-operation abandons in-flight requests; responses for them arriving after reset release are ignored by REQ-030, as outstanding is 0.

Verification
REQ-035 Reset release, gnt=1, 1-cycle memory returning addr^32'hA5A5_0000, ack=1 -> inst_pc_o 0,4,8,...; one instruction per cycle from 2 cycles after first grant.
REQ-036 ack=0, DEPTH=4 -> exactly 4 grants, mem_req_o then low; inst_valid_o held, head pc 0 stable; ack one cycle -> one new request.
REQ-037 3 requests outstanding, 4-cycle memory latency, flush_i with flush_pc_i=32'h0000_1003 -> 3 stale responses dropped; first delivered instruction pc 32'h0000_1000.
REQ-038 halt_i high with 2 in flight -> no new mem_req_o; both delivered; inst_valid_o drops after 2 acks.
REQ-039 flush_pc_i=32'hFFFF_FFF8 -> pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 reset_ni low with 2 outstanding, then 2 late mem_rvalid_i -> ignored; outstanding 0; first instruction pc RESET_PC.
